// File: rtl/pc_sequencer_pkg.sv
// Shared types, default addresses and target arithmetic for the program-counter sequencer.
// Arithmetic is done at a fixed 64-bit width and truncated by the caller, so any XLEN up to 64 works.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_REL = 2'b01,
    PC_ABS = 2'b10,
    PC_REG = 2'b11
  } pc_mode_t;

  localparam logic [31:0] DEFAULT_INIT_PC    = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_4180;
  localparam int          CALC_W             = 64;

  function automatic logic [CALC_W-1:0] calc_target(
    input pc_mode_t          mode,
    input logic [CALC_W-1:0] base,
    input logic [CALC_W-1:0] target,
    input int                offset_w
  );
    logic signed [CALC_W-1:0] offs;
    logic        [CALC_W-1:0] result;
    // Left-align the offset field, then arithmetic-shift back to sign-extend it.
    offs = signed'(target << (CALC_W - offset_w)) >>> (CALC_W - offset_w);
    case (mode)
      PC_SEQ:  result = base + 64'd4;
      PC_REL:  result = base + 64'd4 + $unsigned(offs <<< 2);
      PC_ABS:  result = {base[CALC_W-1:28], target[25:0], 2'b00};
      PC_REG:  result = {target[CALC_W-1:2], 2'b00};
      default: result = base + 64'd4;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Redirect request bus from decode/execute and the fetch-address/RAS outputs of the sequencer.
interface pc_sequencer_if import pc_pkg::*; #(parameter int XLEN = 32);

  logic            stall;
  logic            redir_valid;
  pc_mode_t        redir_mode;
  logic [XLEN-1:0] redir_target;
  logic [XLEN-1:0] redir_base;
  logic            link;
  logic            ret;
  logic            exc_req;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            misalign;
  logic [XLEN-1:0] ras_top;
  logic            ras_top_valid;

  modport master (
    output stall, redir_valid, redir_mode, redir_target, redir_base, link, ret, exc_req,
    input  pc, pc_valid, misalign, ras_top, ras_top_valid
  );

  modport slave (
    input  stall, redir_valid, redir_mode, redir_target, redir_base, link, ret, exc_req,
    output pc, pc_valid, misalign, ras_top, ras_top_valid
  );

endinterface

// File: rtl/pc_sequencer_return_stack.sv
// Circular return-address stack: pushing when full overwrites the oldest entry,
// popping when empty is ignored, push+pop together replaces the top.
module return_stack #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] dataIn,
  output logic [XLEN-1:0] top,
  output logic            valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] topPtr_p0;
  logic [CNT_W-1:0] count_p0;
  logic             empty;
  logic             full;
  logic             advance;

  assign empty   = (count_p0 == '0);
  assign full    = (count_p0 == CNT_W'(DEPTH));
  // A combined push+pop on an empty stack behaves as a plain push.
  assign advance = push && (!pop || empty);

  // ---- stage p0: pointer/count update ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      topPtr_p0 <= '0;
      count_p0  <= '0;
    end else if (advance) begin
      topPtr_p0 <= topPtr_p0 + PTR_W'(1);
      if (!full) count_p0 <= count_p0 + CNT_W'(1);
    end else if (pop && !push && !empty) begin
      topPtr_p0 <= topPtr_p0 - PTR_W'(1);
      count_p0  <= count_p0 - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (advance)   mem[topPtr_p0 + PTR_W'(1)] <= dataIn;
    else if (push) mem[topPtr_p0]             <= dataIn;
  end

  assign top   = empty ? '0 : mem[topPtr_p0];
  assign valid = !empty;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC generator: exception vectoring, stall with pending-redirect latch,
// four jump modes, and a return-address stack feeding predicted returns to fetch.
module pc_sequencer import pc_pkg::*; #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] INIT_PC    = XLEN'(DEFAULT_INIT_PC),
  parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(DEFAULT_EXC_VECTOR),
  parameter int              OFFSET_W   = 16,
  parameter int              RAS_DEPTH  = 4
) (
  input  logic           clock,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  logic [XLEN-1:0] pc_p0;
  logic            pcValid_p0;
  logic            misalign_p0;
  logic            pendValid_p0;
  logic [XLEN-1:0] pendTarget_p0;

  logic [XLEN-1:0] redirBase;
  logic [XLEN-1:0] redirTarget;
  logic            redirMisalign;
  logic [XLEN-1:0] seqPc;
  logic            accept;
  logic [XLEN-1:0] pcNext;
  logic            pendValidNext;
  logic [XLEN-1:0] pendTargetNext;
  logic            misalignNext;

  // Sequential-mode redirects advance from the current fetch PC, not the supplied base.
  assign redirBase     = (bus.redir_mode == PC_SEQ) ? pc_p0 : bus.redir_base;
  assign redirTarget   = XLEN'(calc_target(bus.redir_mode, CALC_W'(redirBase),
                                           CALC_W'(bus.redir_target), OFFSET_W));
  assign redirMisalign = (bus.redir_mode == PC_REG) && (bus.redir_target[1:0] != 2'b00);
  // INIT_PC is fetched once with pc_valid high before sequential advance begins.
  assign seqPc         = pcValid_p0 ? pc_p0 + XLEN'(4) : pc_p0;
  assign accept        = bus.redir_valid && !bus.exc_req;

  always_comb begin
    pcNext         = pc_p0;
    pendValidNext  = pendValid_p0;
    pendTargetNext = pendTarget_p0;
    misalignNext   = 1'b0;
    if (bus.exc_req) begin
      pcNext        = EXC_VECTOR;
      pendValidNext = 1'b0;
    end else if (bus.stall) begin
      if (bus.redir_valid) begin
        pendValidNext  = 1'b1;
        pendTargetNext = redirTarget;
        misalignNext   = redirMisalign;
      end
    end else if (bus.redir_valid) begin
      // A fresh redirect in the release cycle supersedes whatever was pending.
      pcNext        = redirTarget;
      misalignNext  = redirMisalign;
      pendValidNext = 1'b0;
    end else if (pendValid_p0) begin
      pcNext        = pendTarget_p0;
      pendValidNext = 1'b0;
    end else begin
      pcNext = seqPc;
    end
  end

  // ---- stage p0: architectural PC and pending latch ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_p0        <= INIT_PC;
      pcValid_p0   <= 1'b0;
      misalign_p0  <= 1'b0;
      pendValid_p0 <= 1'b0;
    end else begin
      pc_p0        <= pcNext;
      pcValid_p0   <= 1'b1;
      misalign_p0  <= misalignNext;
      pendValid_p0 <= pendValidNext;
    end
  end

  always_ff @(posedge clock) begin
    pendTarget_p0 <= pendTargetNext;
  end

  return_stack #(
    .DEPTH (RAS_DEPTH),
    .XLEN  (XLEN)
  ) u_ras (
    .clock  (clock),
    .reset  (reset),
    .push   (accept && bus.link),
    .pop    (accept && bus.ret),
    .dataIn (bus.redir_base + XLEN'(4)),
    .top    (bus.ras_top),
    .valid  (bus.ras_top_valid)
  );

  assign bus.pc       = pc_p0;
  assign bus.pc_valid = pcValid_p0;
  assign bus.misalign = misalign_p0;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each scenario queues the expected post-edge state
// when it drives a cycle and compares it against the DUT once that edge has passed.
module tb_pc_sequencer;
  import pc_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic        pcValid;
    logic        mis;
    logic [31:0] rasTop;
    logic        rasVld;
  } obs_t;

  logic clock;
  logic reset;
  pc_sequencer_if #(.XLEN(32)) ifc ();

  pc_sequencer #(
    .XLEN       (32),
    .INIT_PC    (32'h0000_3000),
    .EXC_VECTOR (32'h0000_4180),
    .OFFSET_W   (16),
    .RAS_DEPTH  (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  obs_t        sb[$];
  logic [31:0] ras[$];
  logic [31:0] ePc;
  obs_t        got;
  obs_t        exp;
  int          passCnt = 0;
  int          checkCnt = 0;
  localparam obs_t RESET_OBS = '{pc: 32'h3000, pcValid: 1'b0, mis: 1'b0, rasTop: 32'h0, rasVld: 1'b0};

  function automatic obs_t sample();
    obs_t o;
    o = '{pc: ifc.pc, pcValid: ifc.pc_valid, mis: ifc.misalign,
          rasTop: ifc.ras_top, rasVld: ifc.ras_top_valid};
    return o;
  endfunction

  function automatic obs_t expect_obs(logic [31:0] p, logic m);
    obs_t o;
    o = '{pc: p, pcValid: 1'b1, mis: m,
          rasTop: (ras.size() != 0) ? ras[0] : 32'h0, rasVld: (ras.size() != 0)};
    return o;
  endfunction

  function automatic void ras_push(logic [31:0] v);
    ras.push_front(v);
    if (ras.size() > 4) void'(ras.pop_back());
  endfunction

  function automatic void ras_pop();
    if (ras.size() != 0) void'(ras.pop_front());
  endfunction

  task automatic clear_req();
    ifc.stall        = 1'b0;
    ifc.redir_valid  = 1'b0;
    ifc.redir_mode   = PC_SEQ;
    ifc.redir_target = '0;
    ifc.redir_base   = '0;
    ifc.link         = 1'b0;
    ifc.ret          = 1'b0;
    ifc.exc_req      = 1'b0;
  endtask

  task automatic redir(pc_mode_t m, logic [31:0] b, logic [31:0] t);
    ifc.redir_valid  = 1'b1;
    ifc.redir_mode   = m;
    ifc.redir_base   = b;
    ifc.redir_target = t;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_req();
    repeat (2) @(posedge clock);
    #1;
    got = sample(); checkCnt++;
    if (got !== RESET_OBS) $display("FAIL reset_state got %h want %h", got, RESET_OBS);
    else passCnt++;
    @(negedge clock);
    reset = 1'b1;
    ras.delete();
    for (int i = 0; i < 3; i++) begin
      sb.push_back(expect_obs(32'h3000 + 32'(4 * i), 1'b0));
      tick();
      got = sample(); exp = sb.pop_front(); checkCnt++;
      if (got !== exp) $display("FAIL reset_release%0d got %h want %h", i, got, exp);
      else passCnt++;
    end
    ePc = 32'h3008;
  endtask

  task automatic test_jumps();
    pc_mode_t    modes[3]   = '{PC_REL, PC_ABS, PC_REG};
    logic [31:0] bases[3]   = '{32'h3010, 32'h3010, 32'h0};
    logic [31:0] targets[3] = '{32'h0000_FFFE, 32'h0000_0400, 32'h0000_5003};
    logic [31:0] pcs[3]     = '{32'h300C, 32'h1000, 32'h5000};
    logic        miss[3]    = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      redir(modes[i], bases[i], targets[i]);
      sb.push_back(expect_obs(pcs[i], miss[i]));
      tick();
      got = sample(); exp = sb.pop_front(); checkCnt++;
      if (got !== exp) $display("FAIL jump_mode%0d got %h want %h", i, got, exp);
      else passCnt++;
    end
    clear_req();
    sb.push_back(expect_obs(32'h5004, 1'b0));
    tick();
    got = sample(); exp = sb.pop_front(); checkCnt++;
    if (got !== exp) $display("FAIL jump_misalign_clear got %h want %h", got, exp);
    else passCnt++;
    ePc = 32'h5004;
  endtask

  task automatic test_stall_pending();
    logic [31:0] pcs[5] = '{32'h5004, 32'h5004, 32'h5004, 32'h600C, 32'h6010};
    for (int i = 0; i < 5; i++) begin
      clear_req();
      ifc.stall = (i < 3);
      if (i == 0) redir(PC_REL, 32'h5000, 32'h1);
      if (i == 1) redir(PC_REL, 32'h6000, 32'h2);
      sb.push_back(expect_obs(pcs[i], 1'b0));
      tick();
      got = sample(); exp = sb.pop_front(); checkCnt++;
      if (got !== exp) $display("FAIL stall_pending%0d got %h want %h", i, got, exp);
      else passCnt++;
    end
    ePc = 32'h6010;
  endtask

  task automatic test_stall_exc();
    logic [31:0] pcs[4] = '{32'h6010, 32'h4180, 32'h4180, 32'h4184};
    for (int i = 0; i < 4; i++) begin
      clear_req();
      ifc.stall = (i < 3);
      if (i == 0) redir(PC_REL, 32'h7000, 32'h0);
      ifc.exc_req = (i == 1);
      sb.push_back(expect_obs(pcs[i], 1'b0));
      tick();
      got = sample(); exp = sb.pop_front(); checkCnt++;
      if (got !== exp) $display("FAIL stall_exc%0d got %h want %h", i, got, exp);
      else passCnt++;
    end
    ePc = 32'h4184;
  endtask

  task automatic test_release_precedence();
    logic [31:0] pcs[4] = '{32'h4184, 32'h4184, 32'h8004, 32'h8008};
    logic        miss[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      clear_req();
      ifc.stall = (i < 2);
      if (i == 0) redir(PC_REG, 32'h0, 32'h9002);
      if (i == 2) redir(PC_REL, 32'h8000, 32'h0);
      sb.push_back(expect_obs(pcs[i], miss[i]));
      tick();
      got = sample(); exp = sb.pop_front(); checkCnt++;
      if (got !== exp) $display("FAIL release_prec%0d got %h want %h", i, got, exp);
      else passCnt++;
    end
    ePc = 32'h8008;
  endtask

  task automatic test_reset_mid_stall();
    clear_req();
    ifc.stall = 1'b1;
    redir(PC_REL, 32'hA000, 32'h0);
    ifc.link = 1'b1;
    ras_push(32'hA004);
    sb.push_back(expect_obs(ePc, 1'b0));
    tick();
    got = sample(); exp = sb.pop_front(); checkCnt++;
    if (got !== exp) $display("FAIL midstall_latch got %h want %h", got, exp);
    else passCnt++;
    clear_req();
    ifc.stall = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    got = sample(); checkCnt++;
    if (got !== RESET_OBS) $display("FAIL midstall_async_reset got %h want %h", got, RESET_OBS);
    else passCnt++;
    ras.delete();
    @(negedge clock);
    reset = 1'b1;
    ifc.stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(expect_obs(32'h3000 + 32'(4 * i), 1'b0));
      tick();
      got = sample(); exp = sb.pop_front(); checkCnt++;
      if (got !== exp) $display("FAIL midstall_after%0d got %h want %h", i, got, exp);
      else passCnt++;
    end
    ePc = 32'h3004;
  endtask

  task automatic test_ras();
    for (int i = 1; i <= 10; i++) begin
      clear_req();
      redir(PC_SEQ, (i <= 5) ? 32'(i * 32'h100) : 32'h0, 32'h0);
      if (i <= 5) begin
        ifc.link = 1'b1;
        ras_push(32'(i * 32'h100) + 32'h4);
      end else begin
        ifc.ret = 1'b1;
        ras_pop();
      end
      ePc = ePc + 32'h4;
      sb.push_back(expect_obs(ePc, 1'b0));
      tick();
      got = sample(); exp = sb.pop_front(); checkCnt++;
      if (got !== exp) $display("FAIL ras_step%0d got %h want %h", i, got, exp);
      else passCnt++;
    end
  endtask

  task automatic test_back_to_back_link_ret();
    logic [31:0] bases[8] = '{32'h600, 32'h700, 32'h0, 32'hA00, 32'h800, 32'h900, 32'h0, 32'h0};
    logic        lnk[8]   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        rt[8]    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        ex[8]    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      clear_req();
      redir(PC_SEQ, bases[i], 32'h0);
      ifc.link    = lnk[i];
      ifc.ret     = rt[i];
      ifc.exc_req = ex[i];
      if (!ex[i]) begin
        if (lnk[i] && rt[i]) begin
          if (ras.size() == 0) ras.push_front(bases[i] + 32'h4);
          else ras[0] = bases[i] + 32'h4;
        end else if (lnk[i]) ras_push(bases[i] + 32'h4);
        else if (rt[i]) ras_pop();
      end
      ePc = ex[i] ? 32'h4180 : ePc + 32'h4;
      sb.push_back(expect_obs(ePc, 1'b0));
      tick();
      got = sample(); exp = sb.pop_front(); checkCnt++;
      if (got !== exp) $display("FAIL link_ret%0d got %h want %h", i, got, exp);
      else passCnt++;
    end
    clear_req();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want summary");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_jumps();
    test_stall_pending();
    test_stall_exc();
    test_release_precedence();
    test_reset_mid_stall();
    test_ras();
    test_back_to_back_link_ret();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
